// File: rtl/board_state.sv
// Board tile memory: loads from the reset sequencer stream, serves eat requests with
// read-modify-write and pellet accounting, and exposes a 1-cycle read port to the renderer.
module board_state #(
   parameter int unsigned ADDR_W = 10,
   parameter int unsigned DATA_W = 4,
   parameter int unsigned NUM_TILES = 768,
   parameter logic [DATA_W-1:0] TILE_EMPTY = DATA_W'(0),
   parameter logic [DATA_W-1:0] TILE_PELLET = DATA_W'(2),
   parameter logic [DATA_W-1:0] TILE_POWER = DATA_W'(3)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              hold,
   input  logic [ADDR_W-1:0] overwrite_addr,
   input  logic [DATA_W-1:0] initial_data,
   input  logic              eat_req,
   input  logic [ADDR_W-1:0] eat_addr,
   output logic              eat_ack,
   output logic              pellet_eaten,
   output logic              power_eaten,
   output logic [ADDR_W-1:0] pellets_left,
   output logic              level_clear,
   output logic              board_ready,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data
);

   localparam logic [ADDR_W-1:0] NumTilesA = ADDR_W'(NUM_TILES);

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_READ, S_UPDATE} state_t;

   state_t              state;
   logic [DATA_W-1:0]   mem [NUM_TILES];
   logic [ADDR_W-1:0]   eat_addr_q;
   logic                eat_addr_ok_q;
   logic [DATA_W-1:0]   a_data;
   logic [ADDR_W-1:0]   addr_a;
   logic [DATA_W-1:0]   wdata_a;
   logic                we_a;
   logic                ow_ok;
   logic                load_inc;
   logic                eat_hit;

   function automatic logic is_food(input logic [DATA_W-1:0] t);
      return (t == TILE_PELLET) || (t == TILE_POWER);
   endfunction

   assign ow_ok       = overwrite_addr < NumTilesA;
   assign load_inc    = ow_ok && is_food(initial_data);
   assign eat_hit     = eat_addr_ok_q && is_food(a_data);
   assign board_ready = (state != S_LOAD);

   // Port A mux: load stream wins; otherwise read in S_IDLE, write-back in S_UPDATE.
   always_comb begin
      addr_a  = eat_addr_q;
      wdata_a = initial_data;
      we_a    = 1'b0;
      if (hold) begin
         addr_a = overwrite_addr;
         we_a   = ow_ok;
      end else if (state == S_IDLE) begin
         addr_a = eat_addr;
      end else if (state == S_UPDATE && eat_hit) begin
         wdata_a = TILE_EMPTY;
         we_a    = 1'b1;
      end
      if (reset) we_a = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (we_a) mem[addr_a] <= wdata_a;
      a_data <= (addr_a < NumTilesA) ? mem[addr_a] : '0;
   end

   // Renderer port; the non-blocking read returns pre-write data on a same-cycle collision.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_data <= '0;
      end else begin
         rd_data <= (rd_addr < NumTilesA) ? mem[rd_addr] : '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= S_IDLE;
         eat_ack       <= 1'b0;
         pellet_eaten  <= 1'b0;
         power_eaten   <= 1'b0;
         level_clear   <= 1'b0;
         pellets_left  <= '0;
         eat_addr_q    <= '0;
         eat_addr_ok_q <= 1'b0;
      end else begin
         eat_ack      <= 1'b0;
         pellet_eaten <= 1'b0;
         power_eaten  <= 1'b0;
         level_clear  <= 1'b0;
         if (hold) begin
            state <= S_LOAD;
            if (state != S_LOAD) begin
               pellets_left <= load_inc ? ADDR_W'(1) : '0;
            end else if (load_inc && pellets_left < NumTilesA) begin
               pellets_left <= pellets_left + 1'b1;
            end
         end else begin
            unique case (state)
               S_LOAD: state <= S_IDLE;
               S_IDLE: begin
                  // Requester keeps eat_req high through the ack cycle; that is not a new request.
                  if (eat_req && !eat_ack) begin
                     eat_addr_q    <= eat_addr;
                     eat_addr_ok_q <= eat_addr < NumTilesA;
                     state         <= S_READ;
                  end
               end
               S_READ: state <= S_UPDATE;
               S_UPDATE: begin
                  eat_ack <= 1'b1;
                  state   <= S_IDLE;
                  if (eat_hit) begin
                     pellet_eaten <= (a_data == TILE_PELLET);
                     power_eaten  <= (a_data == TILE_POWER);
                     if (pellets_left != '0) pellets_left <= pellets_left - 1'b1;
                     if (pellets_left == ADDR_W'(1)) level_clear <= 1'b1;
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_board_state.sv
// Directed bench for board_state: full load, eats, abort by reload, reset mid-eat.
module tb_board_state;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       hold = 1'b0;
   logic [9:0] overwrite_addr = '0;
   logic [3:0] initial_data = '0;
   logic       eat_req = 1'b0;
   logic [9:0] eat_addr = '0;
   logic       eat_ack, pellet_eaten, power_eaten, level_clear, board_ready;
   logic [9:0] pellets_left;
   logic [9:0] rd_addr = '0;
   logic [3:0] rd_data;

   int n_cmp = 0;
   int n_err = 0;
   int lat, got_pe, got_pw, got_lc, got_pl, got_rd;

   board_state dut (
      .clk(clk), .reset(reset), .hold(hold), .overwrite_addr(overwrite_addr),
      .initial_data(initial_data), .eat_req(eat_req), .eat_addr(eat_addr),
      .eat_ack(eat_ack), .pellet_eaten(pellet_eaten), .power_eaten(power_eaten),
      .pellets_left(pellets_left), .level_clear(level_clear), .board_ready(board_ready),
      .rd_addr(rd_addr), .rd_data(rd_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Wait for eat_ack with eat_req already high; record the ack-cycle outputs.
   task automatic wait_ack(input string tag);
      lat = 0;
      while (eat_ack !== 1'b1 && lat < 12) begin
         step();
         lat++;
      end
      check({tag, "_acked"}, int'(eat_ack === 1'b1), 1);
      got_pe = int'(pellet_eaten);
      got_pw = int'(power_eaten);
      got_lc = int'(level_clear);
      got_pl = int'(pellets_left);
      got_rd = int'(rd_data);
      step();
      eat_req = 1'b0;
   endtask

   task automatic do_eat(input logic [9:0] a, input string tag);
      eat_addr = a;
      rd_addr  = a;
      eat_req  = 1'b1;
      wait_ack(tag);
   endtask

   task automatic read_tile(input logic [9:0] a, input int exp, input string tag);
      rd_addr = a;
      step();
      check(tag, int'(rd_data), exp);
   endtask

   initial begin
      step();
      step();
      check("rst_ack", int'(eat_ack), 0);
      check("rst_pl", int'(pellets_left), 0);
      check("rst_ready", int'(board_ready), 1);
      check("rst_rd", int'(rd_data), 0);
      check("rst_lc", int'(level_clear), 0);
      reset = 1'b0;

      // Full board load: pellets at 5,6,7, power at 8, walls elsewhere.
      hold = 1'b1;
      for (int a = 0; a < 768; a++) begin
         overwrite_addr = 10'(a);
         initial_data   = (a >= 5 && a <= 7) ? 4'd2 : (a == 8) ? 4'd3 : 4'd1;
         step();
         if (a == 100) check("load_ready_low", int'(board_ready), 0);
      end
      hold = 1'b0;
      step();
      check("load_ready_high", int'(board_ready), 1);
      check("load_count", int'(pellets_left), 4);
      read_tile(10'd8, 3, "rd_power");
      read_tile(10'd900, 0, "rd_oob");

      do_eat(10'd5, "eat5");
      check("eat5_lat", lat, 3);
      check("eat5_pe", got_pe, 1);
      check("eat5_pw", got_pw, 0);
      check("eat5_pl", got_pl, 3);
      read_tile(10'd5, 0, "eat5_rd");

      do_eat(10'd0, "eat0");
      check("eat0_pe", got_pe, 0);
      check("eat0_pw", got_pw, 0);
      check("eat0_pl", got_pl, 3);
      read_tile(10'd0, 1, "eat0_wall");

      do_eat(10'd8, "eat8");
      check("eat8_pw", got_pw, 1);
      check("eat8_pe", got_pe, 0);
      check("eat8_pl", got_pl, 2);

      do_eat(10'd6, "eat6");
      check("eat6_pl", got_pl, 1);
      check("eat6_lc", got_lc, 0);
      check("eat6_rbw", got_rd, 2);
      read_tile(10'd6, 0, "eat6_after");

      do_eat(10'd7, "eat7");
      check("eat7_pe", got_pe, 1);
      check("eat7_lc", got_lc, 1);
      check("eat7_pl", got_pl, 0);

      do_eat(10'd7, "eat7_again");
      check("again_pe", got_pe, 0);
      check("again_lc", got_lc, 0);

      do_eat(10'd800, "eat_oob");
      check("oob_pe", got_pe + got_pw, 0);
      check("oob_pl", got_pl, 0);

      // Short reload putting a pellet back at 6.
      hold = 1'b1;
      overwrite_addr = 10'd6; initial_data = 4'd2; step();
      overwrite_addr = 10'd12; initial_data = 4'd1; step();
      hold = 1'b0;
      step();
      check("reload1_pl", int'(pellets_left), 1);

      // Eat at 6 aborted in S_READ by a reload that does not touch 6.
      eat_addr = 10'd6;
      rd_addr  = 10'd6;
      eat_req  = 1'b1;
      step();
      hold = 1'b1;
      overwrite_addr = 10'd12; initial_data = 4'd3; step();
      check("abort_no_ack", int'(eat_ack), 0);
      check("abort_ready", int'(board_ready), 0);
      overwrite_addr = 10'd13; initial_data = 4'd2; step();
      overwrite_addr = 10'd900; initial_data = 4'd3; step();
      hold = 1'b0;
      check("reload2_pl", int'(pellets_left), 2);
      wait_ack("resumed");
      check("resumed_pe", got_pe, 1);
      check("resumed_pl", got_pl, 1);
      read_tile(10'd6, 0, "resumed_rd");

      // Reset while eating the power pellet at 12, in S_UPDATE.
      eat_addr = 10'd12;
      eat_req  = 1'b1;
      step();
      step();
      reset = 1'b1;
      step();
      check("rst_mid_ack", int'(eat_ack), 0);
      check("rst_mid_pw", int'(power_eaten), 0);
      check("rst_mid_pl", int'(pellets_left), 0);
      check("rst_mid_ready", int'(board_ready), 1);
      check("rst_mid_rd", int'(rd_data), 0);
      reset   = 1'b0;
      eat_req = 1'b0;
      read_tile(10'd12, 3, "rst_no_write");
      read_tile(10'd13, 2, "rd_track13");
      read_tile(10'd1000, 0, "rd_track_oob");

      // Count is 0 after reset; eating still reports the tile but must not underflow.
      do_eat(10'd12, "eat12");
      check("eat12_pw", got_pw, 1);
      check("eat12_pl", got_pl, 0);
      check("eat12_lc", got_lc, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/board_state.md
Name: board_state

Overview:
- Owns the 768-tile board memory (32x24 tiles, 4-bit tile codes).
- Consumes the initialisation stream produced by the board reset sequencer (hold / overwrite_addr / initial_data) while hold is high.
- Afterwards serves Pac-Man eat requests with read-modify-write, tracks the remaining pellet count, and flags level clear.
- Provides an independent 1-cycle-latency read port for the VGA tile renderer.

Parameters:
- ADDR_W, 10, tile address width.
- DATA_W, 4, tile code width.
- NUM_TILES, 768, valid addresses 0..767.
- TILE_EMPTY, 4'd0, code written when a pellet is eaten.
- TILE_PELLET, 4'd2, normal pellet code.
- TILE_POWER, 4'd3, power pellet code.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- hold  in  1  init stream active; one write per cycle while high.
- overwrite_addr  in  10  init write address.
- initial_data  in  4  init write data.
- eat_req  in  1  eat request; held high until eat_ack.
- eat_addr  in  10  tile Pac-Man occupies; stable while eat_req high.
- eat_ack  out  1  one-cycle pulse: request completed.
- pellet_eaten  out  1  one-cycle pulse with eat_ack when a TILE_PELLET was consumed.
- power_eaten  out  1  one-cycle pulse with eat_ack when a TILE_POWER was consumed.
- pellets_left  out  10  remaining pellet + power pellet count.
- level_clear  out  1  one-cycle pulse when pellets_left reaches 0 by eating.
- board_ready  out  1  high when not loading (state != S_LOAD).
- rd_addr  in  10  renderer read address.
- rd_data  out  4  tile at rd_addr, registered, 1-cycle latency.

Behaviour:
- Memory is a 768x4 dual-port RAM: port A is read/write for load and eat; port B is read-only for the renderer.
- Memory is not cleared by reset; the reset sequencer reloads it.
- Reset values: eat_ack=0, pellet_eaten=0, power_eaten=0, level_clear=0, pellets_left=0, rd_data=0, state=S_IDLE, board_ready=1.
- Port B: rd_data(n+1) = mem[rd_addr(n)] every cycle, in all states. rd_addr >= 768 returns 0.
- States: S_IDLE, S_LOAD, S_READ, S_UPDATE.
- hold has top priority. From any state, hold=1 goes to S_LOAD.
  - On the first hold cycle, pellets_left is cleared and then incremented if that cycle's data is pellet/power.
  - An in-flight eat is aborted with no ack and no write; the requester keeps eat_req high and is serviced later.
- S_LOAD: each cycle with hold=1 and overwrite_addr < 768:
  - write initial_data at overwrite_addr;
  - pellets_left += 1 if initial_data is TILE_PELLET or TILE_POWER.
  - Addresses >= 768 are ignored.
  - When hold=0, go to S_IDLE. board_ready=0 only while in S_LOAD.
- S_IDLE: eat_req=1 latches eat_addr and goes to S_READ; port A is read this cycle.
- S_READ: the data from port A is available. Go to S_UPDATE.
- S_UPDATE, with tile = data read:
  - tile is pellet/power: write TILE_EMPTY, decrement pellets_left, pulse pellet_eaten or power_eaten.
  - otherwise: no write.
  - In both cases, pulse eat_ack and return to S_IDLE.
  - Total latency is 3 cycles from eat_req sampled to eat_ack.
  - The requester drops eat_req in the cycle after eat_ack. If eat_req is still high in S_IDLE, it is a new request.
- eat_addr >= 768: no read or write. Ack in S_UPDATE with no pellet pulses.
- pellets_left saturates at 0 (decrement at 0 is impossible by construction, but must be guarded). Increment saturates at 768.
- level_clear pulses in the same cycle as eat_ack when pellets_left goes 1 to 0. It never pulses during load or reset.
- Renderer reading the same address as an eat write in the same cycle returns the old data (read-before-write). The new data is visible the next cycle.
- Reset mid-eat or mid-load: next cycle all outputs are at reset values; a partial load leaves memory partially written.

Test Plan:
- Reset, then hold=1 for 768 cycles: addr 0..767, data=2 at addresses 5, 6, 7, data=3 at 8, else 1. Expect pellets_left=4 after hold falls, board_ready 0 during load and 1 after.
- eat_req with eat_addr=5: expect eat_ack and pellet_eaten 3 cycles later, pellets_left=3, and rd_addr=5 returns 0 on the following cycle.
- eat_addr=8: expect power_eaten=1 with eat_ack. eat_addr=0 (wall): expect eat_ack only, pellets_left unchanged, mem[0]=1.
- Eat 6, 7, 8 sequentially after 5: level_clear pulses exactly with the final eat_ack, and pellets_left=0.
- Assert hold during S_READ of an eat at addr 6: expect no eat_ack and no write. Reload sets pellets_left to the new count. After hold falls with eat_req still high, the eat completes.
- Assert reset during S_UPDATE: all outputs 0 the next cycle, state S_IDLE, and rd_data tracks rd_addr with 1-cycle latency throughout.
